// File: rtl/arb_pkg.sv
// Shared types and default sizing for the fetch/data memory arbiter.
package arb_pkg;

    localparam int ARB_ADDR_W     = 16;
    localparam int ARB_DATA_W     = 16;
    localparam int ARB_STARVE_MAX = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        DM_BUSY = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arb_starve.sv
// Fetch-starvation counter: counts back-to-back data grants taken while a fetch waits
// and asks for the next grant to go to fetch once the limit is reached.
module mem_arb_starve
    import arb_pkg::*;
#(
    parameter int STARVE_MAX = ARB_STARVE_MAX
) (
    input  logic clk,
    input  logic rst,
    input  logic if_req,
    input  logic grant_if,
    input  logic grant_dm,
    output logic force_if
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] count;

    // A fetch that stops waiting or finally wins forgets its accumulated starvation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (!if_req || grant_if) begin
            count <= '0;
        end else if (grant_dm && count != LIMIT) begin
            count <= count + CNT_W'(1);
        end
    end

    assign force_if = (count == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store, data side first.
// Defining ARB_STARVE_GUARD_EN adds a bound on how long fetch can be starved.
module mem_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W     = ARB_ADDR_W,
    parameter int DATA_W     = ARB_DATA_W,
    parameter int STARVE_MAX = ARB_STARVE_MAX
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_valid,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              PC_we,
    output logic              busy
);

    if (STARVE_MAX < 1) begin : g_starve_max_check
        $error("mem_arbiter: STARVE_MAX must be at least 1");
    end

    arb_state_t state_q, state_d;
    logic done, arb_en, grant_if, grant_dm, force_if;

    // mem_ready only means something while a transaction is outstanding.
    assign done     = (state_q != IDLE) && mem_ready;
    assign arb_en   = (state_q == IDLE) || mem_ready;
    assign grant_if = arb_en && if_req && (!dm_req || force_if);
    assign grant_dm = arb_en && dm_req && !grant_if;

`ifdef ARB_STARVE_GUARD_EN
    mem_arb_starve #(
        .STARVE_MAX(STARVE_MAX)
    ) u_starve (
        .clk     (clk),
        .rst     (rst),
        .if_req  (if_req),
        .grant_if(grant_if),
        .grant_dm(grant_dm),
        .force_if(force_if)
    );
`else
    assign force_if = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (arb_en) begin
            if (grant_dm) begin
                state_d = DM_BUSY;
            end else if (grant_if) begin
                state_d = IF_BUSY;
            end else begin
                state_d = IDLE;
            end
        end
    end

    // Completion data is captured on the mem_ready edge; the new grant is launched on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
            if_valid  <= 1'b0;
            dm_valid  <= 1'b0;
        end else begin
            if_valid <= done && (state_q == IF_BUSY);
            dm_valid <= done && (state_q == DM_BUSY);
            if (done && state_q == IF_BUSY) begin
                if_rdata <= mem_rdata;
            end
            if (done && state_q == DM_BUSY && !mem_we) begin
                dm_rdata <= mem_rdata;
            end
            if (grant_dm) begin
                mem_req   <= 1'b1;
                mem_we    <= dm_we;
                mem_addr  <= dm_addr;
                mem_wdata <= dm_wdata;
            end else if (grant_if) begin
                mem_req  <= 1'b1;
                mem_we   <= 1'b0;
                mem_addr <= if_addr;
            end else if (arb_en) begin
                mem_req <= 1'b0;
                mem_we  <= 1'b0;
            end
        end
    end

    assign busy  = (state_q != IDLE);
    assign PC_we = if_valid;

endmodule
